// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-master (fetch / load-store) arbiter onto a single
//               registered RAM port, data-priority with fetch starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,

    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,

    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             ready_q;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic             sel_fetch_q;
    logic             wr_q;
    logic             err_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;

    logic             w_arb_en;
    logic             w_launch;
    logic             w_starved;
    logic             w_pick_fetch;
    logic [31:0]      w_addr;
    logic             w_is_wr;
    logic             w_misaligned;
    logic             w_ram_write;

    // ready_q holds off arbitration for the first edge after reset release
    assign w_arb_en     = ready_q && ((state_q == c_IDLE) || (state_q == c_RESP));
    assign w_launch     = w_arb_en && (if_req_i || d_req_i);
    assign w_starved    = (starve_q == c_STARVE_MAX);
    assign w_pick_fetch = if_req_i && (!d_req_i || w_starved);
    assign w_addr       = w_pick_fetch ? if_addr_i : d_addr_i;
    assign w_is_wr      = !w_pick_fetch && d_we_i;
    assign w_misaligned = (w_addr[1:0] != 2'b00);
    assign w_ram_write  = w_is_wr && !w_misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  state_d = w_launch ? c_ISSUE : c_IDLE;
            c_ISSUE: state_d = c_RESP;
            c_RESP:  state_d = w_launch ? c_ISSUE : c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        if_rvalid_o = 1'b0;
        d_rvalid_o  = 1'b0;
        if_rdata_o  = '0;
        d_rdata_o   = '0;
        if_err_o    = 1'b0;
        d_err_o     = 1'b0;
        case (state_q)
            c_ISSUE: begin
                if_gnt_o = sel_fetch_q;
                d_gnt_o  = !sel_fetch_q;
            end
            c_RESP: begin
                if (sel_fetch_q) begin
                    if_rvalid_o = 1'b1;
                    if_err_o    = err_q;
                    if_rdata_o  = err_q ? '0 : data_i;
                end else begin
                    d_rvalid_o = 1'b1;
                    d_err_o    = err_q;
                    d_rdata_o  = (err_q || wr_q) ? '0 : data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Counter clears whenever fetch is idle, so it only measures real waiting
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i) begin
            starve_d = '0;
        end else if (w_launch) begin
            if (w_pick_fetch) begin
                starve_d = '0;
            end else if (!w_starved) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_fetch_q <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else if (w_launch) begin
            sel_fetch_q <= w_pick_fetch;
            wr_q        <= w_is_wr;
            err_q       <= w_misaligned;
            we_q        <= w_ram_write;
            addr_q      <= {w_addr[31:2], 2'b00};
            data_q      <= w_ram_write ? d_wdata_i : '0;
        end else if (state_q == c_ISSUE) begin
            we_q <= 1'b0;
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter with a registered RAM model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0] if_addr, if_rdata_o;
    logic        d_req, d_we, d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0] d_addr, d_wdata, d_rdata_o;
    logic        we_o;
    logic [31:0] addr_o, data_o, data_i;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .we_o(we_o), .addr_o(addr_o), .data_o(data_o), .data_i(data_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // RAM model: registered read, write on we_o
    logic [31:0] mem [0:255];
    bit          written [0:255];

    function automatic logic [31:0] init_word(input logic [7:0] idx);
        case (idx)
            8'h40:   return 32'hDEADBEEF;
            8'h80:   return 32'h12345678;
            8'h20:   return 32'h11111111;
            8'hC0:   return 32'hCAFEF00D;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (we_o) begin
            mem[addr_o[9:2]]     <= data_o;
            written[addr_o[9:2]] <= 1'b1;
        end
        data_i <= written[addr_o[9:2]] ? mem[addr_o[9:2]] : init_word(addr_o[9:2]);
    end

    typedef struct {
        bit          fetch;
        int          cyc;
        logic [31:0] addr;
        bit          we;
        logic [31:0] data;
    } gnt_t;

    typedef struct {
        bit          fetch;
        int          cyc;
        logic [31:0] rdata;
        bit          err;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    gnt_t mg;
    rsp_t mr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pops on grant / response
    always @(negedge clk) begin
        logic [31:0] ard;
        logic        aerr;
        checks++;
        if ((if_gnt_o && d_gnt_o) || (if_rvalid_o && d_rvalid_o) ||
            (!if_rvalid_o && (if_rdata_o != 32'h0 || if_err_o)) ||
            (!d_rvalid_o && (d_rdata_o != 32'h0 || d_err_o)) ||
            (we_o && !d_gnt_o)) begin
            errors++;
            $display("FAIL invariant cyc=%0d: gnt=%b%b rvalid=%b%b we=%b if_rd=%h d_rd=%h",
                     cyc, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, we_o, if_rdata_o, d_rdata_o);
        end
        if (if_gnt_o || d_gnt_o) begin
            checks++;
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL grant cyc=%0d: unexpected grant if=%b d=%b", cyc, if_gnt_o, d_gnt_o);
            end else begin
                mg = gq.pop_front();
                if (!(if_gnt_o === mg.fetch && d_gnt_o === !mg.fetch && cyc == mg.cyc &&
                      addr_o === mg.addr && we_o === mg.we && (!mg.we || data_o === mg.data))) begin
                    errors++;
                    $display("FAIL grant: got fetch=%b cyc=%0d addr=%h we=%b data=%h expected fetch=%b cyc=%0d addr=%h we=%b data=%h",
                             if_gnt_o, cyc, addr_o, we_o, data_o, mg.fetch, mg.cyc, mg.addr, mg.we, mg.data);
                end
            end
        end
        if (if_rvalid_o || d_rvalid_o) begin
            ard  = if_rvalid_o ? if_rdata_o : d_rdata_o;
            aerr = if_rvalid_o ? if_err_o : d_err_o;
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL response cyc=%0d: unexpected rvalid if=%b d=%b", cyc, if_rvalid_o, d_rvalid_o);
            end else begin
                mr = rq.pop_front();
                if (!(if_rvalid_o === mr.fetch && cyc == mr.cyc && ard === mr.rdata && aerr === mr.err)) begin
                    errors++;
                    $display("FAIL response: got fetch=%b cyc=%0d rdata=%h err=%b expected fetch=%b cyc=%0d rdata=%h err=%b",
                             if_rvalid_o, cyc, ard, aerr, mr.fetch, mr.cyc, mr.rdata, mr.err);
                end
            end
        end
    end

    task automatic push_exp(input bit f, input int gc, input logic [31:0] a, input bit we,
                            input logic [31:0] wd, input logic [31:0] er, input bit ee);
        gnt_t g;
        rsp_t r;
        g.fetch = f; g.cyc = gc; g.addr = {a[31:2], 2'b00};
        g.we = we && (a[1:0] == 2'b00); g.data = wd;
        r.fetch = f; r.cyc = gc + 1; r.rdata = er; r.err = ee;
        gq.push_back(g);
        rq.push_back(r);
    endtask

    task automatic do_req(input bit f, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] er, input bit ee);
        push_exp(f, cyc + 1, a, we, wd, er, ee);
        if (f) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int c;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_if_gnt", {31'b0, if_gnt_o}, 32'h0);
        check("rst_d_gnt", {31'b0, d_gnt_o}, 32'h0);
        check("rst_if_rvalid", {31'b0, if_rvalid_o}, 32'h0);
        check("rst_d_rvalid", {31'b0, d_rvalid_o}, 32'h0);
        check("rst_if_rdata", if_rdata_o, 32'h0);
        check("rst_d_rdata", d_rdata_o, 32'h0);
        check("rst_if_err", {31'b0, if_err_o}, 32'h0);
        check("rst_d_err", {31'b0, d_err_o}, 32'h0);
        check("rst_we", {31'b0, we_o}, 32'h0);
        check("rst_addr", addr_o, 32'h0);
        check("rst_data", data_o, 32'h0);

        // Request pending at reset release: no grant after the first edge
        reset = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        push_exp(1'b0, cyc + 2, 32'h200, 1'b0, 32'h0, 32'h12345678, 1'b0);
        @(posedge clk); #1;
        check("first_edge_no_gnt", {31'b0, d_gnt_o}, 32'h0);
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        do_req(1'b1, 1'b0, 32'h100, 32'h0,    32'hDEADBEEF, 1'b0);
        do_req(1'b0, 1'b1, 32'h40,  32'h55AA, 32'h0,        1'b0);
        do_req(1'b0, 1'b0, 32'h40,  32'h0,    32'h55AA,     1'b0);
        do_req(1'b0, 1'b0, 32'h41,  32'h0,    32'h0,        1'b1);
        do_req(1'b0, 1'b1, 32'h42,  32'h99,   32'h0,        1'b1);
        do_req(1'b0, 1'b0, 32'h40,  32'h0,    32'h55AA,     1'b0);
        do_req(1'b1, 1'b0, 32'h102, 32'h0,    32'h0,        1'b1);

        // Both requesters held: D,D,D,D,F,D,D,D,D,F every two cycles
        c = cyc;
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9)
                push_exp(1'b1, c + 1 + 2 * k, 32'h200, 1'b0, 32'h0, 32'h12345678, 1'b0);
            else
                push_exp(1'b0, c + 1 + 2 * k, 32'h300, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
        end
        repeat (19) begin @(posedge clk); #1; end
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Reset during the ISSUE cycle of a write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h77777777;
        @(posedge clk); #1;
        check("rst_mid_we_before", {31'b0, we_o}, 32'h1);
        check("rst_mid_gnt_before", {31'b0, d_gnt_o}, 32'h1);
        #2;
        reset = 1'b1;
        d_req = 1'b0; d_we = 1'b0;
        #1;
        check("rst_mid_we_after", {31'b0, we_o}, 32'h0);
        check("rst_mid_gnt_after", {31'b0, d_gnt_o}, 32'h0);
        check("rst_mid_addr_after", addr_o, 32'h0);
        @(posedge clk); #1;
        check("rst_mid_no_rvalid", {31'b0, d_rvalid_o}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        do_req(1'b0, 1'b0, 32'h80, 32'h0, 32'h11111111, 1'b0);

        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (gq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d grants %0d responses outstanding expected 0 0",
                     gq.size(), rq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive data grants while a fetch request waits.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port if_req_i, input, 1: fetch request; held with if_addr_i until if_gnt_o.
REQ-005 The block SHALL have port if_addr_i, input, 32: fetch byte address.
REQ-006 The block SHALL have port if_gnt_o, output, 1: fetch request accepted, one-cycle pulse.
REQ-007 The block SHALL have ports if_rvalid_o (output, 1), if_rdata_o (output, 32) and if_err_o (output, 1): the fetch response.
REQ-008 The block SHALL have ports d_req_i (input, 1), d_we_i (input, 1), d_addr_i (input, 32) and d_wdata_i (input, 32): the load/store request, held until d_gnt_o.
REQ-009 The block SHALL have ports d_gnt_o (output, 1), d_rvalid_o (output, 1), d_rdata_o (output, 32) and d_err_o (output, 1): data grant and response.
REQ-010 The block SHALL have ports we_o (output, 1), addr_o (output, 32) and data_o (output, 32), all registered: the shared RAM port.
REQ-011 The block SHALL have port data_i, input, 32: RAM read data, valid one cycle after addr_o is presented.

Function
REQ-012 The block SHALL implement FSM states IDLE, ISSUE and RESP.
REQ-013 In IDLE with any request: arbitrate, register the RAM outputs, go to ISSUE.
- With no request: stay in IDLE.
REQ-014 In ISSUE: assert the winner's gnt_o for exactly one cycle, drive the RAM port, and go to RESP.
REQ-015 In RESP: assert the winner's rvalid_o for one cycle and set we_o to 0.
- If any request is pending, arbitrate and go to ISSUE.
- Otherwise go to IDLE.
- Peak throughput SHALL be one access per 2 cycles.
REQ-016 Latency SHALL be: request sampled in cycle T -> gnt in T+1 -> rvalid in T+2.
REQ-017 Arbitration SHALL give priority to data over fetch, except when the starvation counter equals STARVE_LIMIT and if_req_i=1, in which case fetch wins.
REQ-018 The starvation counter SHALL work as follows:
- increment on each data grant made while if_req_i=1;
- clear on a fetch grant or whenever if_req_i=0;
- saturate at STARVE_LIMIT.
REQ-019 For reads, the response rdata_o SHALL equal data_i during the RESP cycle.
- For writes, rdata_o SHALL be 0 and rvalid_o still pulses as the write acknowledge.
REQ-020 For a misaligned request (addr[1:0] != 0), the block SHALL still grant and respond, but:
- we_o stays 0;
- addr_o is the word-aligned address;
- the response carries err_o=1 and rdata_o=0.
REQ-021 A fetch SHALL never assert we_o.
- A data write SHALL set we_o=1 only in the ISSUE cycle, with data_o=d_wdata_i.
REQ-022 Whenever the matching rvalid_o is 0, rdata_o and err_o SHALL be 0.
REQ-023 At most one gnt_o and at most one rvalid_o SHALL be high in any cycle.
REQ-024 A request still high in the cycle after its grant SHALL be treated as a new request.

Reset
REQ-025 Asserting reset SHALL immediately force:
- state to IDLE;
- the starvation counter to 0;
- we_o=0, addr_o=0, data_o=0;
- every gnt, rvalid, rdata and err output to 0.
REQ-026 On reset mid-operation, the in-flight access SHALL be dropped with no response, and a RAM write in ISSUE SHALL be cancelled (we_o=0).
REQ-027 After reset deasserts, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-028 The bench SHALL cover: fetch read of 0x100 with RAM word 0xDEADBEEF -> if_gnt_o at T+1 with addr_o=0x100 and we_o=0; if_rvalid_o at T+2 with if_rdata_o=0xDEADBEEF.
REQ-029 The bench SHALL cover: data write 0x55AA to 0x40, then data read of 0x40 -> we_o=1 for exactly one cycle with data_o=0x55AA; the write acknowledge has d_rdata_o=0; the read returns 0x55AA.
REQ-030 The bench SHALL cover: if_req_i and d_req_i held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F, one grant every 2 cycles.
REQ-031 The bench SHALL cover: data read of 0x41 -> d_gnt_o, no write, d_rvalid_o with d_err_o=1 and d_rdata_o=0.
REQ-032 The bench SHALL cover: reset asserted in the ISSUE cycle of a write -> we_o falls without a clock edge; no d_rvalid_o; the RAM location is unchanged.
